// File: rtl/pc_select_stage.sv
// pc_select_stage
//   Program-counter select stage. It issues a registered PC to a downstream
//   consumer over a valid/ready handshake. The next PC is either pc+4, taken
//   when a transfer completes, or a redirect target, loaded whenever a
//   redirect is requested. A misaligned redirect target parks the block in a
//   sticky error state that only reset can clear.
//
// Ports
//   clk       : clock; all state updates on the rising edge
//   rst_n     : asynchronous active-low reset
//   sel       : 0 = advance to pc+4 on a transfer, 1 = redirect to target
//   target    : redirect address, sampled only when sel=1 in RUN
//   out_ready : downstream accepts pc this cycle
//   out_valid : pc is valid for downstream
//   pc        : current program counter (registered)
//   err       : sticky misaligned-redirect flag
//   xfer_cnt  : count of completed transfers, wraps at 2^CNT_W
module pc_select_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sel,
  input  logic [31:0]      target,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [31:0]      pc,
  output logic             err,
  output logic [CNT_W-1:0] xfer_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_ERR  = 2'b10
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               valid_q, valid_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               xfer;
  logic               redir_ok;

  assign xfer     = (state_q == S_RUN) && valid_q && out_ready;
  assign redir_ok = (target[1:0] == 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_RUN;
      S_RUN:   if (sel && !redir_ok) state_d = S_ERR;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath next values. All outputs come from the _q flops below,
  // so nothing in here reaches a port combinationally.
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        pc_d    = RESET_PC;
        valid_d = 1'b1;
      end
      S_RUN: begin
        // The handshake completes on this edge whatever sel says, so the
        // old pc is counted even when a redirect replaces it.
        if (xfer) cnt_d = cnt_q + CNT_W'(1);
        if (sel) begin
          if (redir_ok) begin
            pc_d = target;
          end else begin
            valid_d = 1'b0;
            err_d   = 1'b1;
          end
        end else if (xfer) begin
          pc_d = pc_q + 32'd4;
        end
      end
      S_ERR: begin
        valid_d = 1'b0;
        err_d   = 1'b1;
      end
      default: valid_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign pc        = pc_q;
  assign err       = err_q;
  assign xfer_cnt  = cnt_q;

endmodule
